// File: rtl/parity_frame_receiver.sv
// rtl/parity_frame_receiver.sv - framed 9-bit serial receiver with parity/stop checking
// Optional error counter compiled in when PARITY_ERR_CNT_EN is defined.
module parity_frame_receiver #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              odd_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_sh;
    logic              perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            data_sh    <= '0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;
            if (sin_valid) begin
                case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                    DATA: begin
                        data_sh[idx] <= sin;
                        if (idx == IDX_W'(DATA_W - 1))
                            state <= PARITY;
                        else
                            idx <= idx + 1'b1;
                    end
                    PARITY: begin
                        perr_q <= (^{data_sh, sin}) ^ odd_sel;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // A word consumed on this same edge frees the slot for the new one.
                        if (!data_valid || data_ready) begin
                            data_out   <= data_sh;
                            parity_err <= perr_q;
                            frame_err  <= ~sin;
                            data_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic             frame_done;
    logic             frame_bad;
    logic [CNT_W-1:0] cnt;

    assign frame_done = sin_valid && (state == STOP);
    assign frame_bad  = perr_q | ~sin;

    // Dropped frames still count; clear has priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (err_clr)
            cnt <= '0;
        else if (frame_done && frame_bad && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

    assign err_count = cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb/tb_parity_frame_receiver.sv - directed self-checking bench for parity_frame_receiver
module tb_parity_frame_receiver;

`ifdef PARITY_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin;
    logic       sin_valid;
    logic       odd_sel;
    logic [8:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fails  = 0;

    parity_frame_receiver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .odd_sel    (odd_sel),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame bits in transmit order: start, data LSB first, parity, stop.
    function automatic logic [11:0] frame(input logic [8:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_vec(input logic [11:0] v, input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            sin       = v[i];
            sin_valid = 1'b1;
            @(posedge clk);
            #1;
            sin_valid = 1'b0;
            sin       = 1'b1;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic consume();
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        sin        = 1'b1;
        sin_valid  = 1'b0;
        odd_sel    = 1'b0;
        data_ready = 1'b0;
        err_clr    = 1'b0;
        #12;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Even mode, 0x0A5: valid must appear only after the 12th strobe.
        send_vec(frame(9'h0A5, 1'b0, 1'b1), 0, 10, 0);
        check("even_not_yet_valid", data_valid, 0);
        send_vec(frame(9'h0A5, 1'b0, 1'b1), 11, 11, 0);
        check("even_valid", data_valid, 1);
        check("even_data", data_out, 9'h0A5);
        check("even_perr", parity_err, 0);
        check("even_ferr", frame_err, 0);
        consume();
        check("consume_clears_valid", data_valid, 0);

        // Odd mode, 0x1FF has nine ones: parity 0 is correct, parity 1 is wrong.
        odd_sel = 1'b1;
        send_vec(frame(9'h1FF, 1'b0, 1'b1), 0, 11, 0);
        check("odd_good_data", data_out, 9'h1FF);
        check("odd_good_perr", parity_err, 0);
        consume();
        send_vec(frame(9'h1FF, 1'b1, 1'b1), 0, 11, 0);
        check("odd_bad_perr", parity_err, 1);
        check("odd_bad_ferr", frame_err, 0);
        check("odd_err_count", err_count, CNT_ON ? 1 : 0);
        consume();
        odd_sel = 1'b0;

        // Stop bit 0, then back-to-back start bit on the very next edge.
        send_vec(frame(9'h003, 1'b0, 1'b0), 0, 11, 0);
        check("ferr_data", data_out, 9'h003);
        check("ferr_flag", frame_err, 1);
        check("ferr_perr", parity_err, 0);
        check("ferr_valid", data_valid, 1);
        check("ferr_err_count", err_count, CNT_ON ? 2 : 0);
        data_ready = 1'b1;
        send_vec(frame(9'h155, 1'b1, 1'b1), 0, 11, 0);
        check("b2b_data", data_out, 9'h155);
        check("b2b_valid", data_valid, 1);
        check("b2b_perr", parity_err, 0);
        check("b2b_ferr", frame_err, 0);
        data_ready = 1'b0;
        consume();

        // Backpressure: second word is dropped with a single overrun pulse.
        send_vec(frame(9'h001, 1'b1, 1'b1), 0, 11, 0);
        check("bp_first_data", data_out, 9'h001);
        check("bp_first_overrun", overrun, 0);
        send_vec(frame(9'h002, 1'b1, 1'b1), 0, 11, 0);
        check("bp_overrun_pulse", overrun, 1);
        check("bp_held_data", data_out, 9'h001);
        check("bp_held_valid", data_valid, 1);
        @(posedge clk);
        #1;
        check("bp_overrun_one_cycle", overrun, 0);
        check("bp_still_held", data_out, 9'h001);
        send_vec(frame(9'h0F0, 1'b0, 1'b1), 0, 10, 0);
        data_ready = 1'b1;
        send_vec(frame(9'h0F0, 1'b0, 1'b1), 11, 11, 0);
        data_ready = 1'b0;
        check("same_edge_load_data", data_out, 9'h0F0);
        check("same_edge_valid", data_valid, 1);
        check("same_edge_no_overrun", overrun, 0);
        consume();

        // Sparse strobes: one bit every third cycle.
        send_vec(frame(9'h12C, 1'b0, 1'b1), 0, 11, 2);
        check("sparse_data", data_out, 9'h12C);
        check("sparse_valid", data_valid, 1);
        check("sparse_perr", parity_err, 0);
        check("sparse_ferr", frame_err, 0);
        consume();

        // Counter saturation and clear priority.
        data_ready = 1'b1;
        for (int k = 0; k < 256; k++)
            send_vec(frame(9'h000, 1'b0, 1'b0), 0, 11, 0);
        check("cnt_saturate", err_count, CNT_ON ? 255 : 0);
        check("cnt_last_ferr", frame_err, 1);
        send_vec(frame(9'h000, 1'b0, 1'b0), 0, 10, 0);
        err_clr = 1'b1;
        send_vec(frame(9'h000, 1'b0, 1'b0), 11, 11, 0);
        err_clr = 1'b0;
        check("cnt_clr_wins", err_count, 0);
        data_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-DATA, then a clean frame.
        send_vec(frame(9'h1FF, 1'b1, 1'b1), 0, 4, 0);
        rst_n = 1'b0;
        #3;
        check("midrst_data_out", data_out, 0);
        check("midrst_valid", data_valid, 0);
        check("midrst_perr", parity_err, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_vec(frame(9'h05A, 1'b0, 1'b1), 0, 11, 0);
        check("post_rst_data", data_out, 9'h05A);
        check("post_rst_valid", data_valid, 1);
        check("post_rst_perr", parity_err, 0);
        check("post_rst_ferr", frame_err, 0);
        check("post_rst_err_count", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
